// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network blocks (LIF neuron and STDP weight update).
// Holds the datapath widths, the neuron state encoding and the saturating adder.
package snn_pkg;

  localparam int WEIGHT_W = 8;
  localparam int MEM_W    = 16;

  typedef enum logic [1:0] {
    INTEGRATE = 2'd0,
    FIRE      = 2'd1,
    REFRACT   = 2'd2
  } lif_state_t;

  // Unsigned add that clamps to all-ones instead of wrapping.
  function automatic logic [MEM_W-1:0] sat_add(input logic [MEM_W-1:0] a,
                                               input logic [MEM_W-1:0] b);
    logic [MEM_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[MEM_W] ? {MEM_W{1'b1}} : sum[MEM_W-1:0];
  endfunction

endpackage

// File: rtl/spike_edge_detect.sv
// One-register rising-edge detector for spike levels.
// The delayed copy of the level updates on every non-reset cycle.
module spike_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic evt
);

  logic level_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign evt = level & ~level_q;

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: integrates weights on presynaptic events, leaks every cycle,
// fires a registered one-cycle post_spike on threshold and then sits out a refractory period.
module lif_neuron
  import snn_pkg::*;
#(
  parameter logic [MEM_W-1:0] THRESHOLD         = 16'h0200,
  parameter int               LEAK_SHIFT        = 4,
  parameter int               REFRACTORY_CYCLES = 4,
  parameter logic [MEM_W-1:0] V_RESET           = 16'h0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pre_spike,
  input  logic [WEIGHT_W-1:0] weight,
  output logic                post_spike,
  output logic [MEM_W-1:0]    membrane,
  output logic                refractory,
  output logic [7:0]          spike_count
);

  lif_state_t          state, state_next;
  logic [7:0]          refr_cnt, refr_cnt_next;
  logic [MEM_W-1:0]    membrane_next;
  logic                post_spike_next;
  logic [7:0]          spike_count_next;
  logic [MEM_W-1:0]    v_leaked;
  logic [MEM_W-1:0]    v_input;
  logic [MEM_W-1:0]    v_next;
  logic                evt;

  spike_edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .level (pre_spike),
    .evt   (evt)
  );

  // Leak never underflows since v >> LEAK_SHIFT <= v; only the add can overflow.
  assign v_leaked = membrane - (membrane >> LEAK_SHIFT);
  assign v_input  = evt ? {{(MEM_W-WEIGHT_W){1'b0}}, weight} : '0;
  assign v_next   = sat_add(v_leaked, v_input);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_next       = state;
    refr_cnt_next    = refr_cnt;
    membrane_next    = membrane;
    post_spike_next  = 1'b0;
    spike_count_next = spike_count;

    unique case (state)
      INTEGRATE: begin
        if (v_next >= THRESHOLD) begin
          membrane_next    = V_RESET;
          post_spike_next  = 1'b1;
          spike_count_next = (spike_count != 8'hFF) ? spike_count + 8'd1 : spike_count;
          state_next       = FIRE;
        end else begin
          membrane_next = v_next;
        end
      end
      FIRE: begin
        membrane_next = V_RESET;
        if (REFRACTORY_CYCLES == 0) begin
          state_next = INTEGRATE;
        end else begin
          refr_cnt_next = 8'(REFRACTORY_CYCLES - 1);
          state_next    = REFRACT;
        end
      end
      REFRACT: begin
        membrane_next = V_RESET;
        if (refr_cnt == 8'd0) state_next = INTEGRATE;
        else                  refr_cnt_next = refr_cnt - 8'd1;
      end
      default: state_next = INTEGRATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= INTEGRATE;
      refr_cnt    <= 8'd0;
      membrane    <= '0;
      post_spike  <= 1'b0;
      refractory  <= 1'b0;
      spike_count <= 8'd0;
    end else begin
      state       <= state_next;
      refr_cnt    <= refr_cnt_next;
      membrane    <= membrane_next;
      post_spike  <= post_spike_next;
      refractory  <= (state_next != INTEGRATE);
      spike_count <= spike_count_next;
    end
  end

endmodule
